// File: rtl/register_unit.sv
`default_nettype none
// ============================================================================
// Module   : register_unit
// Brief    : 32 x XLEN RV32I integer register file, two async read ports plus
//            a debug read port and a committed-write counter. Optional
//            write-first forwarding on RURs1/RURs2 when RU_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module register_unit #(
  parameter int          XLEN    = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_03FC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            RUWr,
  input  logic [XLEN-1:0] RUDataWr,
  output logic [XLEN-1:0] RURs1,
  output logic [XLEN-1:0] RURs2,
  input  logic [4:0]      DbgAddr,
  output logic [XLEN-1:0] DbgData,
  output logic [31:0]     WrCount
);

  localparam logic [XLEN-1:0] SP_RESET = XLEN'(SP_INIT);

  // x0 has no storage; reads of it are forced to zero below
  logic [XLEN-1:0] regs_q [1:31];
  logic [31:0]     wr_count_q;
  logic [31:0]     wr_count_d;
  logic            wr_en;
  logic [XLEN-1:0] rs1_old;
  logic [XLEN-1:0] rs2_old;

  assign wr_en      = RUWr && (rd != 5'd0);
  assign wr_count_d = wr_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      end
      wr_count_q <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= RUDataWr;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rs1_old = '0;
    rs2_old = '0;
    DbgData = '0;
    if (rs1 != 5'd0)     rs1_old = regs_q[rs1];
    if (rs2 != 5'd0)     rs2_old = regs_q[rs2];
    if (DbgAddr != 5'd0) DbgData = regs_q[DbgAddr];
  end

`ifdef RU_BYPASS_EN
  // Write-first: the value being committed this edge is visible now; debug stays read-old
  assign RURs1 = (rst_n && wr_en && (rs1 == rd)) ? RUDataWr : rs1_old;
  assign RURs2 = (rst_n && wr_en && (rs2 == rd)) ? RUDataWr : rs2_old;
`else
  assign RURs1 = rs1_old;
  assign RURs2 = rs2_old;
`endif

  assign WrCount = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_register_unit.sv
`default_nettype none
// Testbench for register_unit: constant vector table, hand-written hazard
// sequences, then randomized traffic against an array-based reference model.
module tb_register_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd, DbgAddr;
  logic        RUWr;
  logic [31:0] RUDataWr;
  logic [31:0] RURs1, RURs2, DbgData, WrCount;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] SP = 32'h0000_03FC;

  register_unit #(.XLEN(32), .SP_INIT(SP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .RUWr     (RUWr),
    .RUDataWr (RUDataWr),
    .RURs1    (RURs1),
    .RURs2    (RURs2),
    .DbgAddr  (DbgAddr),
    .DbgData  (DbgData),
    .WrCount  (WrCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic [31:0] ec;
  } vec_t;

  vec_t vecs[10];

  // reference model: plain array where entry 0 is pinned to zero
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_regs[2] = SP;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic fwd);
    logic [31:0] v;
    v = m_regs[a];
    if (fwd && rst_n && RUWr && rd != 0 && a == rd) v = RUDataWr;
    return v;
  endfunction

  initial begin
    logic fwd;
`ifdef RU_BYPASS_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    rst_n = 1'b0; RUWr = 1'b0; rd = 0; RUDataWr = 0; rs1 = 0; rs2 = 0; DbgAddr = 0;

    // {rst_n, we, rd, wdata, rs1, rs2, dbg, exp_rs1, exp_rs2, exp_dbg, exp_count}
    vecs[0] = '{1'b0, 1'b1, 5'd2,  32'h0000_1234, 5'd2,  5'd0,  5'd2,  SP,            32'h0,         SP,            32'd0};
    vecs[1] = '{1'b1, 1'b1, 5'd5,  32'h0000_000A, 5'd5,  5'd5,  5'd5,  32'h0000_000A, 32'h0000_000A, 32'h0000_000A, 32'd1};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd5,  5'd0,  32'h0,         32'h0000_000A, 32'h0,         32'd1};
    vecs[3] = '{1'b1, 1'b1, 5'd7,  32'h0000_000B, 5'd7,  5'd2,  5'd7,  32'h0000_000B, SP,            32'h0000_000B, 32'd2};
    vecs[4] = '{1'b1, 1'b0, 5'd9,  32'hFFFF_FFFF, 5'd9,  5'd9,  5'd9,  32'h0,         32'h0,         32'h0,         32'd2};
    vecs[5] = '{1'b1, 1'b0, 5'd9,  32'hFFFF_FFFF, 5'd9,  5'd9,  5'd9,  32'h0,         32'h0,         32'h0,         32'd2};
    vecs[6] = '{1'b1, 1'b0, 5'd9,  32'hFFFF_FFFF, 5'd9,  5'd7,  5'd9,  32'h0,         32'h0000_000B, 32'h0,         32'd2};
    vecs[7] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd1,  5'd31, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'd3};
    vecs[8] = '{1'b1, 1'b1, 5'd2,  32'h1234_5678, 5'd2,  5'd2,  5'd2,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'd4};
    vecs[9] = '{1'b0, 1'b1, 5'd5,  32'h5555_5555, 5'd5,  5'd31, 5'd2,  32'h0,         32'h0,         SP,            32'd0};

    // Vector table: drive one edge, then read back with writes disabled
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      rst_n = vecs[v].rst_n; RUWr = vecs[v].we; rd = vecs[v].rd; RUDataWr = vecs[v].wd;
      @(posedge clk);
      #1;
      rst_n = 1'b1; RUWr = 1'b0;
      rs1 = vecs[v].rs1; rs2 = vecs[v].rs2; DbgAddr = vecs[v].dbg;
      #1;
      check($sformatf("vec%0d_rs1", v), RURs1, vecs[v].e1);
      check($sformatf("vec%0d_rs2", v), RURs2, vecs[v].e2);
      check($sformatf("vec%0d_dbg", v), DbgData, vecs[v].ed);
      check($sformatf("vec%0d_cnt", v), WrCount, vecs[v].ec);
    end

    // Full debug sweep of the reset image
    for (int i = 0; i < 32; i++) begin
      DbgAddr = 5'(i);
      #1;
      check($sformatf("sweep_x%0d", i), DbgData, (i == 2) ? SP : 32'h0);
    end

    // x0 reads zero while reset is held
    @(negedge clk);
    rst_n = 1'b0; rs1 = 0; rs2 = 0; DbgAddr = 0;
    #1;
    check("x0_in_reset_rs1", RURs1, 32'h0);
    check("x0_in_reset_dbg", DbgData, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Same-cycle hazard on x7
    @(negedge clk);
    RUWr = 1'b1; rd = 7; RUDataWr = 32'h0B;
    @(negedge clk);
    rd = 7; RUDataWr = 32'h0C; rs1 = 7; rs2 = 7; DbgAddr = 7;
    #1;
    check("hazard_rs1_pre", RURs1, fwd ? 32'h0C : 32'h0B);
    check("hazard_rs2_pre", RURs2, fwd ? 32'h0C : 32'h0B);
    check("hazard_rs1_eq_rs2", RURs1, RURs2);
    check("hazard_dbg_pre", DbgData, 32'h0B);
    @(posedge clk); #1;
    RUWr = 1'b0;
    #1;
    check("hazard_rs1_post", RURs1, 32'h0C);
    check("hazard_dbg_post", DbgData, 32'h0C);
    check("hazard_cnt", WrCount, 32'd2);

    // Randomized traffic against the reference model
    @(negedge clk);
    rst_n = 1'b0; RUWr = 1'b0;
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 24) != 0);
      RUWr     = $urandom_range(0, 2) != 0;
      rd       = 5'($urandom_range(0, 31));
      RUDataWr = $urandom;
      rs1      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      DbgAddr  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rand%0d_rs1", c), RURs1, model_read(rs1, fwd));
      check($sformatf("rand%0d_rs2", c), RURs2, model_read(rs2, fwd));
      check($sformatf("rand%0d_dbg", c), DbgData, model_read(DbgAddr, 1'b0));
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (RUWr && rd != 0) begin
        m_regs[rd] = RUDataWr;
        m_cnt = m_cnt + 1;
      end
      #1;
      check($sformatf("rand%0d_cnt", c), WrCount, m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
